// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the round-robin memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int MEM_ARB_NUM_CH = 2;
    localparam int MEM_ARB_LINE_W = 256;
    localparam int MEM_ARB_ADDR_W = 32;

    // Index width for a channel count; a single channel still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, modulo NUM_CH.
module rr_picker #(
    parameter int NUM_CH = 2,
    parameter int PTR_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [PTR_W-1:0]  gnt_idx,
    output logic              gnt_valid
);

    logic [PTR_W-1:0] idx;

    // Walk from the farthest candidate back to ptr so the nearest requester is written last.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_CH);
            if (req[idx]) begin
                gnt_idx   = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one memory port among NUM_CH channels.
// Optional per-channel grant counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = MEM_ARB_NUM_CH,
    parameter int LINE_W = MEM_ARB_LINE_W,
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    localparam int PTR_W = ptr_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [LINE_W-1:0]        mem_wdata,
    output logic                     mem_read,
    output logic                     mem_write,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_resp,
`ifdef MEM_ARB_PERF_EN
    output logic [NUM_CH*32-1:0]     perf_grant_cnt,
`endif
    output arb_state_t               state,
    output logic [PTR_W-1:0]         rr_ptr
);

    // Handshake: a channel holds ch_read/ch_write (level) until its ch_resp pulse;
    // the memory side holds a strobe until mem_resp, which completes the access that cycle.

    logic [NUM_CH-1:0] req;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [PTR_W-1:0]  gnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [PTR_W-1:0]  rr_next;
    logic              done;

    assign req  = ch_read | ch_write;
    assign done = (state == BUSY) && mem_resp;

    rr_picker #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_picker (
        .req       (req),
        .ptr       (rr_ptr),
        .gnt_idx   (pick_idx),
        .gnt_valid (pick_valid)
    );

    always_comb begin
        rr_next = '0;
        if (NUM_CH > 1 && gnt_q != PTR_W'(NUM_CH - 1)) begin
            rr_next = gnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q     <= pick_idx;
                        addr_q    <= ch_address[pick_idx*ADDR_W +: ADDR_W];
                        wdata_q   <= ch_wdata[pick_idx*LINE_W +: LINE_W];
                        // Write wins when a channel raises both strobes.
                        mem_write <= ch_write[pick_idx];
                        mem_read  <= ~ch_write[pick_idx];
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        rr_ptr    <= rr_next;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ch_resp = '0;
        if (done) begin
            ch_resp[gnt_q] = 1'b1;
        end
    end

    assign ch_rdata    = mem_rdata;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] grant_cnt [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_perf
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                grant_cnt[i] <= '0;
            end else if (done && gnt_q == PTR_W'(i) && grant_cnt[i] != 32'hFFFF_FFFF) begin
                grant_cnt[i] <= grant_cnt[i] + 32'd1;
            end
        end
        assign perf_grant_cnt[i*32 +: 32] = grant_cnt[i];
    end
`endif

endmodule
